// File: rtl/ace_decode_pkg.sv
// -----------------------------------------------------------------------------
// ace_decode_pkg
// Shared definitions for the 4-wide decode-stage controller:
//   - slot count and default instruction / PC widths
//   - bundle struct (4 instructions, per-slot mask, bundle PC)
//   - derived occupancy state {EMPTY, ACTIVE, FULL} used for checks and debug
// No ports (package).
// -----------------------------------------------------------------------------
package ace_decode_pkg;

   localparam int ACE_DEC_SLOTS    = 4;
   localparam int SIZE_AFTER_FETCH = 31;
   localparam int ACE_INST_W       = SIZE_AFTER_FETCH + 1;
   localparam int ACE_PC_W         = 64;

   // Bundle at default widths; the controller re-declares it with its own
   // parameter values so non-default widths stay consistent.
   typedef struct packed {
      logic [ACE_DEC_SLOTS-1:0][ACE_INST_W-1:0] inst;
      logic [ACE_DEC_SLOTS-1:0]                 mask;
      logic [ACE_PC_W-1:0]                      pc;
   } ace_bundle_t;

   // Occupancy is not stored anywhere; it is recomputed from P and S.
   typedef enum logic [1:0] {
      ACE_EMPTY  = 2'd0,
      ACE_ACTIVE = 2'd1,
      ACE_FULL   = 2'd2
   } ace_dec_state_e;

   function automatic ace_dec_state_e ace_state_of(input logic p_nonempty,
                                                   input logic s_valid);
      if (s_valid)         return ACE_FULL;
      else if (p_nonempty) return ACE_ACTIVE;
      else                 return ACE_EMPTY;
   endfunction

endpackage

// File: rtl/ace_slot_consume.sv
// -----------------------------------------------------------------------------
// ace_slot_consume
// Combinational in-order retirement of decode slots: clears the `count`
// lowest-index set bits of `mask`. If `count` exceeds the number of set bits
// every set bit is cleared and `overflow` is raised.
// Ports:
//   mask      in  [3:0]  valid slots currently held
//   count     in  [2:0]  slots consumed this cycle (0..4)
//   next_mask out [3:0]  mask after consumption
//   overflow  out        count larger than popcount(mask)
// -----------------------------------------------------------------------------
module ace_slot_consume
   import ace_decode_pkg::*;
(
   input  logic [ACE_DEC_SLOTS-1:0] mask,
   input  logic [2:0]               count,
   output logic [ACE_DEC_SLOTS-1:0] next_mask,
   output logic                     overflow
);

   // w_rank counts the valid slots older than the one being examined, so a
   // valid slot retires exactly when fewer than `count` older slots exist.
   logic [2:0] w_rank;

   always_comb begin
      w_rank    = '0;
      next_mask = mask;
      for (int i = 0; i < ACE_DEC_SLOTS; i++) begin
         if (mask[i]) begin
            if (w_rank < count) begin
               next_mask[i] = 1'b0;
            end
            w_rank = w_rank + 3'd1;
         end
      end
      overflow = (count > w_rank);
   end

endmodule

// File: rtl/ace_decode_ctrl.sv
// -----------------------------------------------------------------------------
// ace_decode_ctrl
// Decode-stage pipeline controller. Holds the primary bundle P that drives the
// four slot decoders and a one-deep skid bundle S so fetch_ready can come
// straight from a flop. Slots retire in program order as issue consumes them.
// Ports:
//   clk             in   core clock
//   reset_n         in   asynchronous active-low reset
//   flush           in   discard P and S (and any bundle accepted this cycle)
//   fetch_valid     in   fetch presents a bundle
//   fetch_ready     out  controller can accept a bundle (registered)
//   fetch_inst0..3  in   bundle slots, slot 0 oldest
//   fetch_mask      in   per-slot valid of the fetch bundle
//   fetch_pc        in   bundle PC
//   dec_inst0..3    out  registered slots to decoders D0..D3
//   dec_mask        out  valid slots still awaiting issue
//   dec_pc          out  PC of the held bundle
//   issue_count     in   slots consumed this cycle (0..4)
//   dec_stall       out  valid slots held but nothing issued (combinational)
//   issue_err       out  sticky: issue_count exceeded the valid slots
// -----------------------------------------------------------------------------
module ace_decode_ctrl
   import ace_decode_pkg::*;
#(
   parameter int INST_W = SIZE_AFTER_FETCH + 1,
   parameter int PC_W   = 64
)
(
   input  logic              clk,
   input  logic              reset_n,
   input  logic              flush,
   input  logic              fetch_valid,
   output logic              fetch_ready,
   input  logic [INST_W-1:0] fetch_inst0,
   input  logic [INST_W-1:0] fetch_inst1,
   input  logic [INST_W-1:0] fetch_inst2,
   input  logic [INST_W-1:0] fetch_inst3,
   input  logic [3:0]        fetch_mask,
   input  logic [PC_W-1:0]   fetch_pc,
   output logic [INST_W-1:0] dec_inst0,
   output logic [INST_W-1:0] dec_inst1,
   output logic [INST_W-1:0] dec_inst2,
   output logic [INST_W-1:0] dec_inst3,
   output logic [3:0]        dec_mask,
   output logic [PC_W-1:0]   dec_pc,
   input  logic [2:0]        issue_count,
   output logic              dec_stall,
   output logic              issue_err
);

   typedef struct packed {
      logic [ACE_DEC_SLOTS-1:0][INST_W-1:0] inst;
      logic [ACE_DEC_SLOTS-1:0]             mask;
      logic [PC_W-1:0]                      pc;
   } bundle_t;

   bundle_t r_p, r_p_next;
   bundle_t r_s, r_s_next;
   logic    r_s_valid, r_s_valid_next;
   logic    r_fetch_ready;
   logic    r_issue_err, r_issue_err_next;

   bundle_t                               w_fetch;
   logic [ACE_DEC_SLOTS-1:0][INST_W-1:0]  w_fetch_inst;
   logic [ACE_DEC_SLOTS-1:0][INST_W-1:0]  w_dec_inst;
   logic [ACE_DEC_SLOTS-1:0]              w_p_cons_mask;
   logic                                  w_overflow;
   logic                                  w_accept;
   logic                                  w_load;
   logic                                  w_p_drained;
   ace_dec_state_e                        w_state;

   // ------------------------------------------------------------------------
   // Slot packing between the flat ports and the bundle arrays
   // ------------------------------------------------------------------------
   assign w_fetch_inst = {fetch_inst3, fetch_inst2, fetch_inst1, fetch_inst0};
   assign w_fetch      = '{inst: w_fetch_inst, mask: fetch_mask, pc: fetch_pc};

   generate
      for (genvar gi = 0; gi < ACE_DEC_SLOTS; gi++) begin : g_dec_slot
         assign w_dec_inst[gi] = r_p.inst[gi];
      end
   endgenerate

   assign dec_inst0 = w_dec_inst[0];
   assign dec_inst1 = w_dec_inst[1];
   assign dec_inst2 = w_dec_inst[2];
   assign dec_inst3 = w_dec_inst[3];
   assign dec_mask  = r_p.mask;
   assign dec_pc    = r_p.pc;

   // ------------------------------------------------------------------------
   // In-order consumption of P
   // ------------------------------------------------------------------------
   ace_slot_consume u_consume (
      .mask      (r_p.mask),
      .count     (issue_count),
      .next_mask (w_p_cons_mask),
      .overflow  (w_overflow)
   );

   assign w_accept    = fetch_valid && r_fetch_ready;
   // An all-empty bundle is accepted (handshake completes) but never stored.
   assign w_load      = w_accept && (fetch_mask != '0);
   assign w_p_drained = (w_p_cons_mask == '0);
   assign dec_stall   = (r_p.mask != '0) && (issue_count == 3'd0);
   assign fetch_ready = r_fetch_ready;
   assign issue_err   = r_issue_err;
   assign w_state     = ace_state_of(r_p.mask != '0, r_s_valid);

   // ------------------------------------------------------------------------
   // P/S update priority mux
   // ------------------------------------------------------------------------
   always_comb begin
      r_p_next       = r_p;
      r_p_next.mask  = w_p_cons_mask;
      r_s_next       = r_s;
      r_s_valid_next = r_s_valid;

      if (flush) begin
         r_p_next.mask  = '0;
         r_s_valid_next = 1'b0;
      end else if (w_p_drained && r_s_valid) begin
         // fetch_ready is low whenever S is valid, so no accept can collide.
         r_p_next       = r_s;
         r_s_valid_next = 1'b0;
      end else if (w_p_drained && w_load) begin
         r_p_next = w_fetch;
      end else if (w_load) begin
         r_s_next       = w_fetch;
         r_s_valid_next = 1'b1;
      end

      // Overflow in a flush cycle is ignored: the slots are being discarded.
      r_issue_err_next = r_issue_err | (w_overflow & ~flush);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_p           <= '0;
         r_s           <= '0;
         r_s_valid     <= 1'b0;
         r_fetch_ready <= 1'b1;
         r_issue_err   <= 1'b0;
      end else begin
         r_p           <= r_p_next;
         r_s           <= r_s_next;
         r_s_valid     <= r_s_valid_next;
         r_fetch_ready <= ~r_s_valid_next;
         r_issue_err   <= r_issue_err_next;
      end
   end

   // A skid bundle is only ever parked behind a non-empty primary bundle.
   a_full_implies_p: assert property (@(posedge clk) disable iff (!reset_n)
      (w_state != ACE_FULL) || (r_p.mask != '0));

endmodule

// File: tb/tb_ace_decode_ctrl.sv
// -----------------------------------------------------------------------------
// tb_ace_decode_ctrl
// Directed steps followed by randomized traffic for ace_decode_ctrl. The
// reference model treats the controller as an ordered queue of at most two
// bundles: the head is what the decoders see, issue removes the oldest valid
// slots of the head, emptied heads fall away, and new non-empty bundles join
// the tail while the queue has room.
// -----------------------------------------------------------------------------
module tb_ace_decode_ctrl;
   import ace_decode_pkg::*;

   logic        clk;
   logic        reset_n;
   logic        flush;
   logic        fetch_valid;
   logic        fetch_ready;
   logic [31:0] fetch_inst0, fetch_inst1, fetch_inst2, fetch_inst3;
   logic [3:0]  fetch_mask;
   logic [63:0] fetch_pc;
   logic [31:0] dec_inst0, dec_inst1, dec_inst2, dec_inst3;
   logic [3:0]  dec_mask;
   logic [63:0] dec_pc;
   logic [2:0]  issue_count;
   logic        dec_stall;
   logic        issue_err;

   ace_decode_ctrl #(.INST_W(32), .PC_W(64)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .flush       (flush),
      .fetch_valid (fetch_valid),
      .fetch_ready (fetch_ready),
      .fetch_inst0 (fetch_inst0),
      .fetch_inst1 (fetch_inst1),
      .fetch_inst2 (fetch_inst2),
      .fetch_inst3 (fetch_inst3),
      .fetch_mask  (fetch_mask),
      .fetch_pc    (fetch_pc),
      .dec_inst0   (dec_inst0),
      .dec_inst1   (dec_inst1),
      .dec_inst2   (dec_inst2),
      .dec_inst3   (dec_inst3),
      .dec_mask    (dec_mask),
      .dec_pc      (dec_pc),
      .issue_count (issue_count),
      .dec_stall   (dec_stall),
      .issue_err   (issue_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded its time budget");
      $fatal(1, "watchdog");
   end

   typedef struct packed {
      logic [3:0][31:0] inst;
      logic [3:0]       mask;
      logic [63:0]      pc;
   } mb_t;

   mb_t              mq[$];
   logic [3:0][31:0] sh_inst;
   logic [63:0]      sh_pc;
   logic             exp_err;
   int               n_tests;
   int               n_fail;

   logic [31:0] dinst [4];
   assign dinst[0] = dec_inst0;
   assign dinst[1] = dec_inst1;
   assign dinst[2] = dec_inst2;
   assign dinst[3] = dec_inst3;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      exp_err = 1'b0;
      sh_inst = '0;
      sh_pc   = '0;
   endtask

   // One clock of the queue-level model, evaluated with the inputs of the cycle.
   task automatic model_step(input bit fv, input logic [3:0] fm, input logic [63:0] pc,
                             input logic [3:0][31:0] fi, input bit fl, input logic [2:0] cnt);
      bit   room;
      int   slots[$];
      int   n;
      mb_t  h;
      mb_t  nb;
      room = (mq.size() < 2);
      if (mq.size() > 0) begin
         for (int i = 0; i < 4; i++) if (mq[0].mask[i]) slots.push_back(i);
      end
      if (!fl && (int'(cnt) > slots.size())) exp_err = 1'b1;
      n = (int'(cnt) < slots.size()) ? int'(cnt) : slots.size();
      if (mq.size() > 0) begin
         h = mq[0];
         for (int k = 0; k < n; k++) h.mask[slots.pop_front()] = 1'b0;
         mq[0] = h;
      end
      if (fl) begin
         mq.delete();
      end else begin
         if (mq.size() > 0 && mq[0].mask == 4'b0) void'(mq.pop_front());
         if (fv && room && fm != 4'b0) begin
            nb.inst = fi;
            nb.mask = fm;
            nb.pc   = pc;
            mq.push_back(nb);
         end
      end
      if (mq.size() > 0) begin
         sh_inst = mq[0].inst;
         sh_pc   = mq[0].pc;
      end
   endtask

   task automatic check_outputs();
      logic [3:0] em;
      em = (mq.size() > 0) ? mq[0].mask : 4'b0;
      chk("dec_mask", {60'b0, dec_mask}, {60'b0, em});
      chk("fetch_ready", {63'b0, fetch_ready}, {63'b0, (mq.size() < 2)});
      chk("issue_err", {63'b0, issue_err}, {63'b0, exp_err});
      for (int i = 0; i < 4; i++) begin
         if (em[i]) chk($sformatf("dec_inst%0d", i), {32'b0, dinst[i]}, {32'b0, sh_inst[i]});
      end
      if (em != 4'b0) chk("dec_pc", dec_pc, sh_pc);
   endtask

   // Drive one cycle starting at a falling edge; check the combinational stall
   // before the edge and the registered outputs at the next falling edge.
   task automatic cyc(input bit fv, input logic [3:0] fm, input logic [63:0] pc,
                      input bit fl, input logic [2:0] cnt);
      logic [3:0][31:0] fi;
      bit               es;
      for (int i = 0; i < 4; i++) fi[i] = $urandom;
      fetch_valid = fv;
      fetch_mask  = fm;
      fetch_pc    = pc;
      flush       = fl;
      issue_count = cnt;
      fetch_inst0 = fi[0];
      fetch_inst1 = fi[1];
      fetch_inst2 = fi[2];
      fetch_inst3 = fi[3];
      #1;
      es = (mq.size() > 0) && (cnt == 3'd0);
      chk("dec_stall", {63'b0, dec_stall}, {63'b0, es});
      model_step(fv, fm, pc, fi, fl, cnt);
      @(posedge clk);
      @(negedge clk);
      check_outputs();
      $display("[TB] t=%0t fv=%0b fm=%b pc=%0h fl=%0b cnt=%0d -> mask=%b pc=%0h rdy=%0b err=%0b",
               $time, fv, fm, pc, fl, cnt, dec_mask, dec_pc, fetch_ready, issue_err);
   endtask

   task automatic idle_inputs();
      fetch_valid = 1'b0;
      fetch_mask  = 4'b0;
      fetch_pc    = '0;
      flush       = 1'b0;
      issue_count = 3'd0;
      fetch_inst0 = '0;
      fetch_inst1 = '0;
      fetch_inst2 = '0;
      fetch_inst3 = '0;
   endtask

   task automatic chk_reset_vals();
      chk("rst_dec_mask", {60'b0, dec_mask}, 64'd0);
      chk("rst_dec_pc", dec_pc, 64'd0);
      chk("rst_dec_inst", {dec_inst1, dec_inst0}, 64'd0);
      chk("rst_dec_inst_hi", {dec_inst3, dec_inst2}, 64'd0);
      chk("rst_fetch_ready", {63'b0, fetch_ready}, 64'd1);
      chk("rst_dec_stall", {63'b0, dec_stall}, 64'd0);
      chk("rst_issue_err", {63'b0, issue_err}, 64'd0);
   endtask

   // Reset asserted away from any clock edge: state must clear at once.
   task automatic async_reset();
      idle_inputs();
      #2 reset_n = 1'b0;
      #1;
      chk_reset_vals();
      model_reset();
      $display("[TB] t=%0t async reset mid-operation", $time);
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      reset_n = 1'b0;
      idle_inputs();
      model_reset();
      repeat (2) @(negedge clk);
      chk_reset_vals();
      $display("[TB] t=%0t reset values checked", $time);
      reset_n = 1'b1;

      // Back-to-back full bundles with full issue.
      cyc(1, 4'hF, 64'h1000, 0, 0);
      chk("b2b_first_mask", {60'b0, dec_mask}, 64'hF);
      chk("b2b_first_pc", dec_pc, 64'h1000);
      for (int i = 1; i <= 4; i++) begin
         cyc(1, 4'hF, 64'h1000 + 64'(i) * 64'h10, 0, 4);
         chk("b2b_pc", dec_pc, 64'h1000 + 64'(i) * 64'h10);
         chk("b2b_ready", {63'b0, fetch_ready}, 64'd1);
      end
      cyc(0, 4'h0, 64'h0, 0, 4);

      // Partial mask retired one slot at a time.
      cyc(1, 4'b1011, 64'h2000, 0, 0);
      cyc(0, 4'h0, 64'h0, 0, 1);
      chk("step_1010", {60'b0, dec_mask}, 64'b1010);
      cyc(0, 4'h0, 64'h0, 0, 1);
      chk("step_1000", {60'b0, dec_mask}, 64'b1000);
      cyc(1, 4'hF, 64'h3000, 0, 1);
      chk("step_next_mask", {60'b0, dec_mask}, 64'hF);
      chk("step_next_pc", dec_pc, 64'h3000);
      cyc(0, 4'h0, 64'h0, 0, 4);

      // Stalled issue: second bundle parks in S, then moves to P.
      cyc(1, 4'hF, 64'h4000, 0, 0);
      cyc(1, 4'hF, 64'h5000, 0, 0);
      chk("skid_ready_low", {63'b0, fetch_ready}, 64'd0);
      chk("skid_p_pc", dec_pc, 64'h4000);
      cyc(1, 4'hF, 64'h6000, 0, 4);
      chk("skid_ready_back", {63'b0, fetch_ready}, 64'd1);
      chk("skid_moved_pc", dec_pc, 64'h5000);

      // Flush from FULL, then flush in ACTIVE with an accepted bundle.
      cyc(1, 4'b0110, 64'h7000, 0, 0);
      chk("full_ready", {63'b0, fetch_ready}, 64'd0);
      cyc(1, 4'hF, 64'h8000, 1, 0);
      chk("flush_mask", {60'b0, dec_mask}, 64'd0);
      chk("flush_ready", {63'b0, fetch_ready}, 64'd1);
      cyc(0, 4'h0, 64'h0, 0, 0);
      cyc(1, 4'hF, 64'h9000, 0, 0);
      cyc(1, 4'hF, 64'hA000, 1, 0);
      cyc(0, 4'h0, 64'h0, 0, 0);
      chk("flush_drop_mask", {60'b0, dec_mask}, 64'd0);

      // Empty fetch bundle in EMPTY.
      cyc(1, 4'h0, 64'hB000, 0, 0);
      chk("zero_mask", {60'b0, dec_mask}, 64'd0);
      chk("zero_ready", {63'b0, fetch_ready}, 64'd1);
      cyc(0, 4'h0, 64'h0, 0, 0);

      // Over-issue sets the sticky error, which survives a flush.
      chk("err_clear_before", {63'b0, issue_err}, 64'd0);
      cyc(1, 4'b0011, 64'hC000, 0, 0);
      cyc(0, 4'h0, 64'h0, 0, 3);
      chk("over_mask", {60'b0, dec_mask}, 64'd0);
      chk("over_err", {63'b0, issue_err}, 64'd1);
      cyc(0, 4'h0, 64'h0, 1, 0);
      chk("err_after_flush", {63'b0, issue_err}, 64'd1);

      // Reset while FULL.
      cyc(1, 4'hF, 64'hD000, 0, 0);
      cyc(1, 4'hF, 64'hE000, 0, 0);
      async_reset();
      cyc(0, 4'h0, 64'h0, 0, 0);

      // Randomized traffic against the queue model.
      for (int r = 0; r < 400; r++) begin
         bit          fv;
         bit          fl;
         logic [3:0]  fm;
         logic [2:0]  cnt;
         logic [63:0] pc;
         fv  = ($urandom_range(0, 3) != 0);
         fm  = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
         cnt = 3'($urandom_range(0, 4));
         fl  = ($urandom_range(0, 19) == 0);
         pc  = {32'h0, $urandom};
         cyc(fv, fm, pc, fl, cnt);
         if (r % 100 == 99) async_reset();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ace_decode_ctrl.md
# ace_decode_ctrl

Pipeline controller for the 4-wide decode stage. It sits between fetch and the four slot decoders, and holds the registered 4-instruction bundle that drives the decoder inputs. It retires slots in program order as downstream issue consumes them, and buffers one extra fetch bundle in a skid register so that `fetch_ready` stays registered. It also handles pipeline flush.

## Interface
Parameters:
- `INST_W`, default `SIZE_AFTER_FETCH+1`: width of one fetched instruction.
- `PC_W`, default 64: bundle PC width.

Ports:
- `clk`  in  1  core clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  discard all held bundles.
- `fetch_valid`  in  1  fetch presents a bundle.
- `fetch_ready`  out  1  controller can accept a bundle.
- `fetch_inst0..3`  in  INST_W each  bundle slots, slot 0 oldest.
- `fetch_mask`  in  4  per-slot valid.
- `fetch_pc`  in  PC_W  bundle PC.
- `dec_inst0..3`  out  INST_W each  registered slots to decoders D0..D3.
- `dec_mask`  out  4  valid slots still awaiting issue.
- `dec_pc`  out  PC_W  PC of the held bundle.
- `issue_count`  in  3  slots consumed this cycle (0..4).
- `dec_stall`  out  1  `dec_mask != 0 && issue_count == 0`.
- `issue_err`  out  1  sticky: `issue_count` exceeded the valid slots.

## Operation
- Two bundle registers:
  - P (primary) drives the `dec_*` outputs.
  - S (skid) holds one bundle with its own mask and PC.
- State is derived, not encoded separately:
  - EMPTY: P empty and S empty.
  - ACTIVE: P non-empty and S empty.
  - FULL: S valid.
  - Invariant: S valid implies P non-empty.
- `fetch_ready = !S_valid`, driven straight from a flop.
- Accept means `fetch_valid && fetch_ready`.
- Consumption: clear the `min(issue_count, popcount(dec_mask))` lowest-index set bits of P's mask. Call the result P'.
  - If `issue_count` exceeds the popcount, clamp it and set `issue_err`.
  - `issue_err` clears only on reset.
- P/S update priority, highest first:
  1. `flush`: P mask = 0 and S_valid = 0. Any fetch bundle accepted in the same cycle is dropped.
  2. P' empty and S valid: S moves to P and S_valid becomes 0. An accepted bundle cannot occur here, because `fetch_ready` is 0.
  3. P' empty and accept: the fetch bundle loads P directly (bypass).
  4. P' non-empty and accept: the fetch bundle loads S.
  5. Otherwise P takes P', and S holds.
- A bundle with `fetch_mask == 0` is accepted and discarded. It never loads P or S.
- Slot data in P for cleared mask bits holds its stale value. The `dec_inst` values are meaningful only where `dec_mask` is set.
- Consumption is strictly in order. A slot is never cleared while an older valid slot remains.

## Timing
- Reset values (asynchronous):
  - `dec_inst0..3 = 0`, `dec_mask = 0`, `dec_pc = 0`.
  - S cleared.
  - `fetch_ready = 1`, `dec_stall = 0`, `issue_err = 0`.
- Latency:
  - A fetch bundle accepted in cycle N appears on `dec_*` in cycle N+1 when P' is empty.
  - Otherwise it appears in the cycle after P drains.
- Back-to-back: a full 4-slot issue every cycle gives zero-bubble throughput directly from fetch to P.
- `fetch_ready` falls the cycle after a bundle enters S. It rises the cycle after S transfers to P or is flushed.
- Flush:
  - `dec_mask = 0` in the next cycle.
  - `issue_count` in the flush cycle has no effect on `issue_err`.
- Reset mid-operation: all state clears immediately, with no partial bundle retained.
- `dec_stall` and the clamp logic are combinational from P's mask and `issue_count`. All other outputs are registered.

## Structure
- Shared package `ace_decode_pkg` holds:
  - `ACE_DEC_SLOTS = 4`.
  - The bundle struct/typedef: 4 instructions, mask, PC.
  - The derived-state enum {EMPTY, ACTIVE, FULL}, for assertions and debug.
- Sub-module `ace_slot_consume`: combinational. Inputs are `mask[3:0]` and `count[2:0]`. Outputs are `next_mask[3:0]` and `overflow`, using lowest-set-bit-first clearing.
- The top level holds the P and S registers and the update priority mux.

## Test plan
- Reset, then fetch bundle mask 1111, PC 0x1000, `issue_count = 4` every cycle:
  - `dec_mask = 1111` and `dec_pc = 0x1000` one cycle later.
  - A new bundle every cycle with `fetch_ready` held at 1.
- Mask 1011, then `issue_count` 1, 1, 1:
  - `dec_mask` steps 1010 → 1000 → 0000.
  - The next bundle appears the cycle after the third issue.
- Hold `issue_count = 0` while fetch sends two bundles:
  - The first stays in P and the second goes to S.
  - `fetch_ready = 0` one cycle later.
  - `issue_count = 4` moves S to P and restores `fetch_ready = 1` next cycle.
- `flush` asserted in FULL with `fetch_valid = 1`:
  - Next cycle `dec_mask = 0000` and `fetch_ready = 1`.
  - The flushed-cycle bundle never appears.
- `dec_mask = 0011` with `issue_count = 3`:
  - `dec_mask` becomes 0000 and `issue_err` rises.
  - `issue_err` stays 1 through a flush and clears only on `reset_n` low.
- Fetch with `fetch_mask = 0000` in EMPTY:
  - Accepted and `dec_mask` stays 0000.
  - `dec_stall` stays 0 and `fetch_ready` stays 1.
